// File: rtl/osd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : osd_cmd_sequencer
//  Purpose  : Round-robin sequencer driving the OSD host bus for two
//             requesters (0 = menu renderer, 1 = info/popup engine). Each
//             grant emits one framed transaction: a command word followed by
//             N data words read from the winner's buffer through a shared
//             read port, with strobe setup/high timing and a post-frame gap.
//  Ports    : clk_sys, reset_n          - clock, async active-low reset
//             req, cmd_in, len_in       - per-requester request/command/count
//             ack, done                 - per-requester grant / finish pulses
//             rd_en, rd_sel, rd_addr,
//             rd_data                   - shared buffer read port (1-cycle)
//             io_osd, io_strobe, io_din - OSD host bus
//             busy                      - high whenever not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module osd_cmd_sequencer #(
  parameter int STROBE_LOW  = 2,
  parameter int STROBE_HIGH = 2,
  parameter int GAP         = 4,
  parameter int LEN_W       = 13
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [1:0]         req,
  input  logic [15:0]        cmd_in,
  input  logic [2*LEN_W-1:0] len_in,
  output logic [1:0]         ack,
  output logic [1:0]         done,
  output logic               rd_en,
  output logic               rd_sel,
  output logic [LEN_W-1:0]   rd_addr,
  input  logic [15:0]        rd_data,
  output logic               io_osd,
  output logic               io_strobe,
  output logic [15:0]        io_din,
  output logic               busy
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_CMD_LO = 3'd1;
  localparam logic [2:0] c_ST_CMD_HI = 3'd2;
  localparam logic [2:0] c_ST_FETCH  = 3'd3;
  localparam logic [2:0] c_ST_CAPT   = 3'd4;
  localparam logic [2:0] c_ST_DAT_LO = 3'd5;
  localparam logic [2:0] c_ST_DAT_HI = 3'd6;
  localparam logic [2:0] c_ST_GAP    = 3'd7;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_SL_LAST  = CNT_W'(STROBE_LOW - 1);
  // CAPT already supplies the first low cycle of a data word
  localparam logic [CNT_W-1:0] c_DLO_LAST = CNT_W'((STROBE_LOW >= 2) ? (STROBE_LOW - 2) : 0);
  localparam logic [CNT_W-1:0] c_SH_LAST  = CNT_W'(STROBE_HIGH - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [LEN_W:0]   c_IDX_ONE  = {{LEN_W{1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             g_q, g_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [15:0]      din_q, din_d;
  logic [1:0]       ack_q, ack_d;

  logic             w_g;
  logic [LEN_W:0]   w_idx_nxt;

  // Contention alternates away from the last winner; a lone requester wins
  assign w_g       = (req == 2'b11) ? ~last_q : req[1];
  // One bit wider than the count so the compare never wraps at max length
  assign w_idx_nxt = {1'b0, idx_q} + c_IDX_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    last_d  = last_q;
    len_d   = len_q;
    idx_d   = idx_q;
    din_d   = din_q;
    ack_d   = 2'b00;
    case (state_q)
      c_ST_IDLE: begin
        if (req != 2'b00) begin
          g_d     = w_g;
          last_d  = w_g;
          ack_d   = w_g ? 2'b10 : 2'b01;
          len_d   = w_g ? len_in[2*LEN_W-1:LEN_W] : len_in[LEN_W-1:0];
          din_d   = {8'h00, (w_g ? cmd_in[15:8] : cmd_in[7:0])};
          cnt_d   = '0;
          state_d = c_ST_CMD_LO;
        end
      end
      c_ST_CMD_LO: begin
        if (cnt_q == c_SL_LAST) begin
          cnt_d   = '0;
          state_d = c_ST_CMD_HI;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      c_ST_CMD_HI: begin
        if (cnt_q == c_SH_LAST) begin
          cnt_d = '0;
          if (len_q == '0) begin
            din_d   = '0;
            state_d = c_ST_GAP;
          end else begin
            idx_d   = '0;
            state_d = c_ST_FETCH;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      c_ST_FETCH: begin
        state_d = c_ST_CAPT;
      end
      c_ST_CAPT: begin
        din_d = rd_data;
        cnt_d = '0;
        if (STROBE_LOW == 1) begin
          state_d = c_ST_DAT_HI;
        end else begin
          state_d = c_ST_DAT_LO;
        end
      end
      c_ST_DAT_LO: begin
        if (cnt_q == c_DLO_LAST) begin
          cnt_d   = '0;
          state_d = c_ST_DAT_HI;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      c_ST_DAT_HI: begin
        if (cnt_q == c_SH_LAST) begin
          cnt_d = '0;
          if (w_idx_nxt == {1'b0, len_q}) begin
            din_d   = '0;
            state_d = c_ST_GAP;
          end else begin
            idx_d   = w_idx_nxt[LEN_W-1:0];
            state_d = c_ST_FETCH;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      c_ST_GAP: begin
        if (cnt_q == c_GAP_LAST) begin
          cnt_d   = '0;
          state_d = c_ST_IDLE;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_ST_IDLE;
      cnt_q   <= '0;
      g_q     <= 1'b0;
      last_q  <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      din_q   <= '0;
      ack_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      last_q  <= last_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
    end
  end

  // Bus controls decode straight from state so reset drops them without a clock
  assign busy      = (state_q != c_ST_IDLE);
  assign io_osd    = busy && (state_q != c_ST_GAP);
  assign io_strobe = (state_q == c_ST_CMD_HI) || (state_q == c_ST_DAT_HI);
  assign rd_en     = (state_q == c_ST_FETCH);
  assign rd_sel    = g_q;
  assign rd_addr   = idx_q;
  // Read data is presented during CAPT itself so it meets the full low-time setup
  assign io_din    = (state_q == c_ST_CAPT) ? rd_data : din_q;
  assign ack       = ack_q;
  assign done      = ((state_q == c_ST_GAP) && (cnt_q == c_GAP_LAST)) ?
                     (g_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_osd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_osd_cmd_sequencer
//  Purpose  : Directed self-checking bench for osd_cmd_sequencer, covering a
//             default-timing instance and a minimum-timing instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_osd_cmd_sequencer;

  localparam int LEN_W = 13;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  logic reset_n;

  // default-timing instance
  logic [1:0]         req;
  logic [15:0]        cmd_in;
  logic [2*LEN_W-1:0] len_in;
  logic [1:0]         ack, done;
  logic               rd_en, rd_sel;
  logic [LEN_W-1:0]   rd_addr;
  logic [15:0]        rd_data;
  logic               io_osd, io_strobe, busy;
  logic [15:0]        io_din;

  // minimum-timing instance
  logic [1:0]         k_req;
  logic [15:0]        k_cmd;
  logic [2*LEN_W-1:0] k_len;
  logic [1:0]         k_ack, k_done;
  logic               k_rd_en, k_rd_sel;
  logic [LEN_W-1:0]   k_rd_addr;
  logic [15:0]        k_rd_data;
  logic               k_osd, k_stb, k_busy;
  logic [15:0]        k_din;

  osd_cmd_sequencer #(.STROBE_LOW(2), .STROBE_HIGH(2), .GAP(4), .LEN_W(LEN_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(req), .cmd_in(cmd_in), .len_in(len_in),
    .ack(ack), .done(done), .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_data(rd_data), .io_osd(io_osd), .io_strobe(io_strobe), .io_din(io_din), .busy(busy)
  );

  osd_cmd_sequencer #(.STROBE_LOW(1), .STROBE_HIGH(1), .GAP(1), .LEN_W(LEN_W)) dut_c (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(k_req), .cmd_in(k_cmd), .len_in(k_len),
    .ack(k_ack), .done(k_done), .rd_en(k_rd_en), .rd_sel(k_rd_sel), .rd_addr(k_rd_addr),
    .rd_data(k_rd_data), .io_osd(k_osd), .io_strobe(k_stb), .io_din(k_din), .busy(k_busy)
  );

  // Buffer models: data valid exactly one cycle after rd_en, garbage otherwise
  always @(posedge clk_sys) begin
    rd_data   <= rd_en   ? (16'h00A0 + {3'b000, rd_addr})   : 16'hDEAD;
    k_rd_data <= k_rd_en ? (16'h00A0 + {3'b000, k_rd_addr}) : 16'hDEAD;
  end

  // Observation mux so the same checking tasks serve both instances
  logic             sel;
  logic [1:0]       m_ack, m_done;
  logic             m_rd_en, m_rd_sel, m_osd, m_stb, m_busy;
  logic [LEN_W-1:0] m_rd_addr;
  logic [15:0]      m_din;
  always_comb begin
    m_ack     = sel ? k_ack     : ack;
    m_done    = sel ? k_done    : done;
    m_rd_en   = sel ? k_rd_en   : rd_en;
    m_rd_sel  = sel ? k_rd_sel  : rd_sel;
    m_rd_addr = sel ? k_rd_addr : rd_addr;
    m_osd     = sel ? k_osd     : io_osd;
    m_stb     = sel ? k_stb     : io_strobe;
    m_busy    = sel ? k_busy    : busy;
    m_din     = sel ? k_din     : io_din;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  bit          drop_req0;
  logic [15:0] exp_words[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_ack(input string tag, input logic [1:0] exp, input int exp_wait);
    int w = 0;
    while (m_ack == 2'b00 && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_ack"}, {30'd0, m_ack}, {30'd0, exp});
    if (exp_wait > 0) chk({tag, "_ack_wait"}, w, exp_wait);
  endtask

  // Called on the ack cycle; follows the transaction up to its done pulse
  task automatic watch(input string tag, input logic [1:0] exp_done, input int exp_cyc,
                       input int exp_osd, input int stab_min, input logic exp_sel);
    int          cyc = 1;
    int          osd_hi = 0;
    int          nw = 0;
    int          nrd = 0;
    int          stab = 1;
    logic        prev_stb;
    logic [15:0] prev_din;
    prev_stb = m_stb;
    prev_din = m_din;
    if (m_osd) osd_hi++;
    while (m_done == 2'b00 && cyc < 300) begin
      step();
      cyc++;
      if (drop_req0 && cyc == 2) req[0] = 1'b0;
      if (m_osd) osd_hi++;
      if (m_rd_en) begin
        chk({tag, "_rd_sel"}, {31'd0, m_rd_sel}, {31'd0, exp_sel});
        chk({tag, "_rd_addr"}, {19'd0, m_rd_addr}, nrd);
        nrd++;
      end
      if (m_stb && !prev_stb) begin
        if (nw < exp_words.size())
          chk({tag, "_word"}, {16'd0, m_din}, {16'd0, exp_words[nw]});
        else
          chk({tag, "_extra_strobe"}, nw, exp_words.size());
        chk({tag, "_setup_ok"}, {31'd0, (stab >= stab_min)}, 32'd1);
        nw++;
      end
      if (m_stb && m_din != prev_din)
        chk({tag, "_din_moved_while_high"}, {16'd0, m_din}, {16'd0, prev_din});
      if (!m_stb) stab = (!prev_stb && m_din == prev_din) ? stab + 1 : 1;
      prev_stb = m_stb;
      prev_din = m_din;
    end
    chk({tag, "_done"}, {30'd0, m_done}, {30'd0, exp_done});
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_osd_high"}, osd_hi, exp_osd);
    chk({tag, "_strobes"}, nw, exp_words.size());
    chk({tag, "_reads"}, nrd, exp_words.size() - 1);
    chk({tag, "_busy_in_gap"}, {31'd0, m_busy}, 32'd1);
    chk({tag, "_osd_in_gap"}, {31'd0, m_osd}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rises;
    logic prv;
    sel = 1'b0; reset_n = 1'b0; drop_req0 = 1'b0;
    req = '0; cmd_in = '0; len_in = '0;
    k_req = '0; k_cmd = '0; k_len = '0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_osd", {31'd0, io_osd}, 0);
    chk("rst_strobe", {31'd0, io_strobe}, 0);
    chk("rst_din", {16'd0, io_din}, 0);
    chk("rst_ack", {30'd0, ack}, 0);
    chk("rst_done", {30'd0, done}, 0);
    chk("rst_rd_en", {31'd0, rd_en}, 0);
    reset_n = 1'b1;
    step();

    // single command, len 0
    cmd_in = {8'h00, 8'h41}; len_in = '0; req = 2'b01;
    wait_ack("t1", 2'b01, 1);
    chk("t1_din_at_ack", {16'd0, io_din}, 32'h0041);
    chk("t1_osd_at_ack", {31'd0, io_osd}, 1);
    chk("t1_strobe_at_ack", {31'd0, io_strobe}, 0);
    req = 2'b00;
    exp_words = '{16'h0041};
    watch("t1", 2'b01, 8, 4, 2, 1'b0);

    // write burst from requester 1
    cmd_in = {8'h20, 8'h00}; len_in = {13'd3, 13'd0}; req = 2'b10;
    wait_ack("t2", 2'b10, 0);
    req = 2'b00;
    exp_words = '{16'h0020, 16'h00A0, 16'h00A1, 16'h00A2};
    watch("t2", 2'b10, 23, 19, 2, 1'b1);

    // contention: both held, last winner was 1
    cmd_in = {8'h20, 8'h41}; len_in = '0; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack("t3", (k % 2 == 1) ? 2'b10 : 2'b01, (k == 0) ? 0 : 2);
      if (k == 3) req = 2'b00;
      exp_words = '{((k % 2 == 1) ? 16'h0020 : 16'h0041)};
      watch("t3", (k % 2 == 1) ? 2'b10 : 2'b01, 8, 4, 2, (k % 2 == 1));
    end

    // request dropped one cycle after ack
    cmd_in = {8'h20, 8'h41}; len_in = {13'd0, 13'd5}; req = 2'b01;
    wait_ack("t4", 2'b01, 2);
    drop_req0 = 1'b1;
    exp_words = '{16'h0041, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    watch("t4", 2'b01, 33, 29, 2, 1'b0);
    drop_req0 = 1'b0;
    step();
    step();
    chk("t4_idle_after", {31'd0, busy}, 0);

    // reset during the second data word's high phase
    cmd_in = {8'h20, 8'h41}; len_in = {13'd3, 13'd0}; req = 2'b10;
    wait_ack("t5", 2'b10, 0);
    req = 2'b00;
    rises = 0;
    prv = io_strobe;
    for (int i = 0; i < 60 && rises < 3; i++) begin
      step();
      if (io_strobe && !prv) rises++;
      prv = io_strobe;
    end
    chk("t5_reached_dat_hi", {31'd0, io_strobe}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_osd", {31'd0, io_osd}, 0);
    chk("t5_rst_strobe", {31'd0, io_strobe}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_done", {30'd0, done}, 0);
    step();
    step();
    reset_n = 1'b1;
    cmd_in = {8'h20, 8'h41}; len_in = '0; req = 2'b01;
    wait_ack("t5r", 2'b01, 1);
    chk("t5r_din_at_ack", {16'd0, io_din}, 32'h0041);
    req = 2'b00;
    exp_words = '{16'h0041};
    watch("t5r", 2'b01, 8, 4, 2, 1'b0);

    // minimum timing instance, len 2
    sel = 1'b1;
    k_cmd = {8'h00, 8'h55}; k_len = {13'd0, 13'd2}; k_req = 2'b01;
    wait_ack("t6", 2'b01, 1);
    k_req = 2'b00;
    exp_words = '{16'h0055, 16'h00A0, 16'h00A1};
    watch("t6", 2'b01, 9, 8, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
